if_fetch_stage: RTL and testbench

- Instruction fetch stage for the RV32I SoC, directly upstream of the decoder.
- Owns the PC and issues in-order word requests to instruction memory over a req/gnt + rvalid interface.
- Buffers returned words in a small FIFO and presents {instruction, pc} to the decoder with a valid/ready handshake.
- Accepts redirects (taken branch, JAL, JALR) from EX, flushing buffered and in-flight fetches.

---
 rtl/if_fetch_stage.sv | 140 ++++++++++++++
 tb/tb_if_fetch_stage.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_stage.sv
// RV32I instruction fetch: owns the PC, issues in-order word fetches
// and buffers returned words for the decoder.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  input  logic        instr_ready_i
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [31:0]   NOP     = 32'h0000_0013;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] ONE     = CW'(1);

  logic [31:0]   pc_q, pc_d;
  logic [31:0]   last_pc_q;
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] discard_q, discard_d;
  logic [CW-1:0] count_q;
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW-1:0] pq_wr_q, pq_rd_q;

  logic [31:0] fifo_instr [FIFO_DEPTH];
  logic [31:0] fifo_pc    [FIFO_DEPTH];
  logic [31:0] pq_pc      [FIFO_DEPTH];

  logic [CW:0] credit_sum;
  logic        credit;
  logic        fire;
  logic        push;
  logic        pop;
  logic        empty;
  logic        full;
  logic        unused_pc_lsb;

  assign unused_pc_lsb = ^redirect_pc_i[1:0];

  // Credits cover both in-flight and buffered words.
  assign credit_sum = {1'b0, outst_q} + {1'b0, count_q};
  assign credit     = credit_sum < {1'b0, DEPTH_C};

  assign imem_req_o  = rst_ni & credit & ~redirect_i;
  assign imem_addr_o = pc_q;
  assign fire        = imem_req_o & imem_gnt_i;

  assign empty = (count_q == '0);
  assign full  = (count_q == DEPTH_C);
  assign push  = imem_rvalid_i & ~redirect_i
               & (discard_q == '0);
  assign pop   = ~empty & instr_ready_i & ~redirect_i;

  assign instr_valid_o = ~empty;
  assign instr_o       = empty ? NOP : fifo_instr[rd_ptr_q];
  assign instr_pc_o    = empty ? last_pc_q : fifo_pc[rd_ptr_q];

  always_comb begin
    pc_d = pc_q;
    unique case (1'b1)
      redirect_i: pc_d = {redirect_pc_i[31:2], 2'b00};
      fire:       pc_d = pc_q + 32'd4;
      default:    pc_d = pc_q;
    endcase
  end

  // A redirect turns every response still owed into a discard.
  always_comb begin
    outst_d   = outst_q + CW'(fire) - CW'(imem_rvalid_i);
    discard_d = discard_q;
    if (redirect_i) begin
      discard_d = outst_d;
    end else if (imem_rvalid_i && discard_q != '0) begin
      discard_d = discard_q - ONE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q      <= RESET_PC;
      outst_q   <= '0;
      discard_q <= '0;
      pq_wr_q   <= '0;
      pq_rd_q   <= '0;
      last_pc_q <= '0;
    end else begin
      pc_q      <= pc_d;
      outst_q   <= outst_d;
      discard_q <= discard_d;
      pq_wr_q   <= pq_wr_q + AW'(fire);
      pq_rd_q   <= pq_rd_q + AW'(imem_rvalid_i);
      if (!empty) begin
        last_pc_q <= fifo_pc[rd_ptr_q];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (redirect_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_q + AW'(push);
      rd_ptr_q <= rd_ptr_q + AW'(pop);
      count_q  <= count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_instr[wr_ptr_q] <= imem_rdata_i;
      fifo_pc[wr_ptr_q]    <= pq_pc[pq_rd_q];
    end
    if (fire) begin
      pq_pc[pq_wr_q] <= pc_q;
    end
  end

  a_no_overflow: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    !(push && full && !pop)
  );

endmodule

// File: tb/tb_if_fetch_stage.sv
// Randomized bench for if_fetch_stage against a queue-level
// reference model, plus directed pins on known sequences.
module tb_if_fetch_stage;

  localparam int          DEPTH = 2;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b1;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i = 1'b0;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        instr_ready_i = 1'b0;

  if_fetch_stage #(
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .instr_valid_o (instr_valid_o),
    .instr_o       (instr_o),
    .instr_pc_o    (instr_pc_o),
    .instr_ready_i (instr_ready_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct { logic [31:0] pc; bit stale; } fl_t;
  typedef struct { logic [31:0] instr; logic [31:0] pc; } fe_t;
  typedef struct { logic [31:0] addr; int due; } mr_t;

  fl_t inflight[$];
  fe_t fifo_m[$];
  mr_t memq[$];

  logic [31:0] m_pc;
  logic [31:0] m_last_pc;
  int          cyc;
  int          errors = 0;
  int          checks = 0;
  bit          chk_en = 1'b0;

  int          gnt_pct = 100;
  int          ready_pct = 100;
  int          redir_pct = 0;
  int          lat_min = 1;
  int          lat_max = 1;
  bit          force_redir = 1'b0;
  bit          redir_on_rv = 1'b0;
  logic [31:0] redir_target = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A3C, a[31:16]} + 32'h1357_9BDF;
  endfunction

  function automatic bit m_req();
    return rst_ni && !redirect_i
        && (inflight.size() + fifo_m.size() < DEPTH);
  endfunction

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t",
               name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  // Per-cycle comparison against the reference model.
  always @(negedge clk_i) begin
    if (chk_en) begin
      check("req", 32'(imem_req_o), 32'(m_req()));
      check("addr", imem_addr_o, m_pc);
      check("valid", 32'(instr_valid_o), 32'(fifo_m.size() > 0));
      check("instr", instr_o,
            fifo_m.size() > 0 ? fifo_m[0].instr : NOP);
      check("instr_pc", instr_pc_o,
            fifo_m.size() > 0 ? fifo_m[0].pc : m_last_pc);
    end
  end

  task automatic model_reset();
    inflight.delete();
    fifo_m.delete();
    memq.delete();
    m_pc      = 32'h0000_0000;
    m_last_pc = 32'h0000_0000;
    cyc       = 0;
  endtask

  task automatic drive();
    imem_gnt_i    = int'($urandom_range(99, 0)) < gnt_pct;
    instr_ready_i = int'($urandom_range(99, 0)) < ready_pct;
    imem_rvalid_i = (memq.size() > 0) && (memq[0].due <= cyc);
    imem_rdata_i  = imem_rvalid_i ? mem_word(memq[0].addr)
                                  : $urandom();
    redirect_i    = 1'b0;
    redirect_pc_i = $urandom();
    if (force_redir || (redir_on_rv && imem_rvalid_i
                        && imem_gnt_i)) begin
      redirect_i    = 1'b1;
      redirect_pc_i = redir_target;
      force_redir   = 1'b0;
      redir_on_rv   = 1'b0;
    end else if (int'($urandom_range(99, 0)) < redir_pct) begin
      redirect_i = 1'b1;
    end
  endtask

  // Advance one clock: apply the held inputs to the model, then
  // draw the next cycle's inputs.
  task automatic step();
    bit  fire;
    bit  popm;
    fl_t h;
    @(posedge clk_i);
    #1;
    fire = m_req() && imem_gnt_i;
    cyc++;
    if (fifo_m.size() > 0) m_last_pc = fifo_m[0].pc;
    if (imem_rvalid_i) void'(memq.pop_front());
    if (fire) begin
      memq.push_back('{m_pc,
        cyc + int'($urandom_range(lat_max, lat_min)) - 1});
    end
    if (redirect_i) begin
      fifo_m.delete();
      foreach (inflight[i]) inflight[i].stale = 1'b1;
      if (imem_rvalid_i) void'(inflight.pop_front());
      m_pc = {redirect_pc_i[31:2], 2'b00};
    end else begin
      popm = (fifo_m.size() > 0) && instr_ready_i;
      if (popm) void'(fifo_m.pop_front());
      if (imem_rvalid_i) begin
        h = inflight.pop_front();
        if (!h.stale) fifo_m.push_back('{mem_word(h.pc), h.pc});
      end
      if (fire) begin
        inflight.push_back('{m_pc, 1'b0});
        m_pc = m_pc + 32'd4;
      end
    end
    drive();
  endtask

  task automatic tick();
    step();
    @(negedge clk_i);
  endtask

  task automatic release_reset();
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    model_reset();
    drive();
    chk_en = 1'b1;
    @(negedge clk_i);
  endtask

  task automatic wait_valid(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (instr_valid_o) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) timeout(name);
  endtask

  initial begin
    #1 rst_ni = 1'b0;
    #1;
    check("rst_req", 32'(imem_req_o), 32'd0);
    check("rst_valid", 32'(instr_valid_o), 32'd0);
    check("rst_instr", instr_o, NOP);
    check("rst_pc", instr_pc_o, 32'h0);
    check("rst_addr", imem_addr_o, 32'h0);

    release_reset();
    check("c0_req", 32'(imem_req_o), 32'd1);
    check("c0_addr", imem_addr_o, 32'h0);
    tick();
    tick();
    check("c2_valid", 32'(instr_valid_o), 32'd1);
    check("c2_pc", instr_pc_o, 32'h0);
    tick();
    check("c3_pc", instr_pc_o, 32'h4);
    tick();
    tick();
    check("c5_pc", instr_pc_o, 32'h8);

    ready_pct = 0;
    repeat (5) tick();
    check("stall_req", 32'(imem_req_o), 32'd0);
    check("stall_valid", 32'(instr_valid_o), 32'd1);
    ready_pct = 100;
    repeat (6) tick();

    gnt_pct = 0;
    repeat (8) tick();
    redir_target = 32'h0000_0008;
    force_redir  = 1'b1;
    tick();
    check("redir_req", 32'(imem_req_o), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_req", 32'(imem_req_o), 32'd1);
      check("hold_addr", imem_addr_o, 32'h8);
    end
    gnt_pct = 100;
    tick();
    check("gnt_addr", imem_addr_o, 32'h8);
    tick();
    check("after_gnt", imem_addr_o, 32'hC);

    lat_min = 3;
    lat_max = 3;
    repeat (6) tick();
    redir_target = 32'h0000_0100;
    force_redir  = 1'b1;
    tick();
    tick();
    check("r100_addr", imem_addr_o, 32'h100);
    wait_valid("r100_valid");
    check("r100_pc", instr_pc_o, 32'h100);

    lat_min = 1;
    lat_max = 1;
    redir_target = 32'h0000_0203;
    redir_on_rv  = 1'b1;
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
        tick();
        if (redirect_i) begin
          seen = 1'b1;
          break;
        end
      end
      if (!seen) timeout("r203_trigger");
    end
    tick();
    check("r203_addr", imem_addr_o, 32'h200);
    wait_valid("r203_valid");
    check("r203_pc", instr_pc_o, 32'h200);

    redir_target = 32'hFFFF_FFFC;
    force_redir  = 1'b1;
    tick();
    tick();
    check("wrap_addr", imem_addr_o, 32'hFFFF_FFFC);
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
        if (imem_req_o) begin
          seen = 1'b1;
          break;
        end
        tick();
      end
      if (!seen) timeout("wrap_req");
    end
    tick();
    check("wrap_next", imem_addr_o, 32'h0);

    gnt_pct   = 70;
    ready_pct = 70;
    redir_pct = 5;
    lat_min   = 1;
    lat_max   = 4;
    repeat (3000) tick();

    #2;
    chk_en = 1'b0;
    rst_ni = 1'b0;
    #1;
    check("arst_req", 32'(imem_req_o), 32'd0);
    check("arst_valid", 32'(instr_valid_o), 32'd0);
    check("arst_instr", instr_o, NOP);
    check("arst_pc", instr_pc_o, 32'h0);
    check("arst_addr", imem_addr_o, 32'h0);
    imem_gnt_i    = 1'b0;
    imem_rvalid_i = 1'b0;
    redirect_i    = 1'b0;
    instr_ready_i = 1'b0;
    model_reset();
    release_reset();
    repeat (500) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
